// File: rtl/fetch_stage.sv
// Fetch stage and Fetch/Decode pipeline register for the pipelined ARM core.
// Owns PCF, runs the req/ready instruction-memory handshake and feeds Decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcWB,
    input  logic [31:0] ResultWB,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} FetchStateT;

    FetchStateT  stateQ;
    logic        reqQ;
    logic [31:2] reqAddrQ;
    logic [31:0] holdInstrQ;
    logic [31:0] pcQ;
    logic [31:0] pcD;
    logic [31:0] instrDQ;
    logic [31:0] pcPlus8DQ;
    logic        validDQ;

    logic        redir;
    logic [31:0] target;
    logic        avail;
    logic        deliver;
    logic [31:0] instrF;
    logic [31:0] pcPlus4;

    always_comb begin
        redir   = PCSrcWB | BranchTakenE;
        target  = PCSrcWB ? ResultWB : BranchTargetE;
        avail   = ((stateQ == FETCH) & imem_ready) | (stateQ == HOLD);
        instrF  = (stateQ == HOLD) ? holdInstrQ : imem_rdata;
        deliver = avail & ~StallF & ~redir;
        pcPlus4 = pcQ + 32'd4;
        pcD     = pcQ;
        if (redir) begin
            pcD = target;
        end else if (deliver) begin
            pcD = pcPlus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcQ <= RESET_PC;
        end else begin
            pcQ <= pcD;
        end
    end

    // A response already in flight when a redirect lands must still be taken
    // and thrown away (DROP) before the new target can be requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ     <= IDLE;
            reqQ       <= 1'b0;
            reqAddrQ   <= RESET_PC[31:2];
            holdInstrQ <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    stateQ <= FETCH;
                    reqQ   <= 1'b1;
                    if (redir) begin
                        reqAddrQ <= target[31:2];
                    end
                end
                FETCH: begin
                    if (redir) begin
                        if (imem_ready) begin
                            reqAddrQ <= target[31:2];
                        end else begin
                            stateQ <= DROP;
                        end
                    end else if (imem_ready) begin
                        if (!StallF) begin
                            reqAddrQ <= pcPlus4[31:2];
                        end else begin
                            holdInstrQ <= imem_rdata;
                            stateQ     <= HOLD;
                            reqQ       <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redir) begin
                        reqAddrQ <= target[31:2];
                        stateQ   <= FETCH;
                        reqQ     <= 1'b1;
                    end else if (!StallF) begin
                        reqAddrQ <= pcPlus4[31:2];
                        stateQ   <= FETCH;
                        reqQ     <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        reqAddrQ <= redir ? target[31:2] : pcQ[31:2];
                        stateQ   <= FETCH;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                    reqQ   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instrDQ   <= NOP_INSTR;
            pcPlus8DQ <= '0;
            validDQ   <= 1'b0;
        end else if (FlushD) begin
            instrDQ <= NOP_INSTR;
            validDQ <= 1'b0;
        end else if (StallD) begin
            instrDQ   <= instrDQ;
            pcPlus8DQ <= pcPlus8DQ;
            validDQ   <= validDQ;
        end else if (deliver) begin
            instrDQ   <= instrF;
            pcPlus8DQ <= pcQ + 32'd8;
            validDQ   <= 1'b1;
        end else begin
            instrDQ <= NOP_INSTR;
            validDQ <= 1'b0;
        end
    end

    assign imem_req   = reqQ;
    assign imem_addr  = {reqAddrQ, 2'b00};
    assign PCF        = pcQ;
    assign InstrD     = instrDQ;
    assign PCPlus8D   = pcPlus8DQ;
    assign ValidD     = validDQ;
    assign FetchBusyF = ~avail;

    // The hazard unit never stalls Decode without also stalling Fetch.
    stallOrderCheck: assert property (@(posedge clk) disable iff (reset) !(StallD && !StallF));

endmodule
